mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single on-chip SRAM port between NREQ requesters. Default wiring:
//  0 = MPU table refill, 1 = CPU data, 2 = CPU instruction fetch.
//  Round-robin arbitration, one transaction in flight. Optional per-requester lock
//  keeps back-to-back bursts (e.g. MPU table reload) on one requester, capped by LOCK_MAX.
//  Sits between requesters and SRAM. Owns mem_wen/mem_addr/mem_wdata exclusively.
// PARAMETERS
//  NREQ       3     number of requesters (2..8)
//  MEM_WORDS  1024  SRAM depth in 32-bit words; word addresses >= MEM_WORDS are out of range
//  ADDR_W     22    word-address width
//  MEM_LAT    1     SRAM read latency in cycles (>=1)
//  LOCK_MAX   16    max consecutive locked grants before forced rotation
// PORTS
//  clk        in   1          clock
//  resetn     in   1          synchronous reset, active-low
//  rq_valid   in   NREQ       request pending, held until rq_ready
//  rq_lock    in   NREQ       keep grant for this requester's next request
//  rq_addr    in   NREQ*ADDR_W  word address, slice i = requester i
//  rq_wstrb   in   NREQ*4     byte write strobes, 0 = read
//  rq_wdata   in   NREQ*32    write data
//  rq_ready   out  NREQ       one-cycle completion pulse
//  rq_rdata   out  32         read data, valid while any rq_ready bit is high
//  grant_id   out  3          index of the current/last granted requester
//  busy       out  1          transaction in flight (state != IDLE)
//  mem_wen    out  4          SRAM byte write enable
//  mem_addr   out  ADDR_W     SRAM word address
//  mem_wdata  out  32         SRAM write data
//  mem_rdata  in   32         SRAM read data, MEM_LAT cycles after mem_addr
// BEHAVIOUR
//  Reset: state IDLE. rq_ready=0, rq_rdata=0, grant_id=0, busy=0, mem_wen=0,
//   mem_addr=0, mem_wdata=0. RR pointer=0, lock count=0. Reset mid-transaction
//   aborts it: no ready pulse, mem_wen=0 from the next cycle.
//  FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
//  IDLE: if any rq_valid, pick a winner. The locked requester wins if its valid is high.
//   Otherwise the first valid requester at or after the RR pointer, wrapping at NREQ.
//   Register mem_addr/mem_wdata/mem_wen and grant_id from the winner. Go to ACCESS.
//  ACCESS (1 cycle): mem_wen is high only in this cycle. If addr >= MEM_WORDS, mem_wen is
//   forced to 0 and the response rdata is forced to 0. Go to WAIT, wait counter = MEM_LAT-1.
//  WAIT: count down. At 0, capture mem_rdata into rq_rdata (writes: capture as well,
//   content don't-care). Go to RESP.
//  RESP (1 cycle): rq_ready[grant_id]=1. RR pointer = grant_id+1 mod NREQ.
//   If rq_lock[grant_id] and lock count < LOCK_MAX-1: lock held, lock count++.
//   Otherwise lock released, count=0. Go to IDLE.
//  Latency: rq_valid seen in IDLE at T -> rq_ready high at T+2+MEM_LAT.
//   Minimum spacing between grants is 3+MEM_LAT cycles.
//  Requesters drop rq_valid the cycle after rq_ready. A valid still high in the IDLE
//   cycle right after RESP is treated as a new request.
//  rq_valid falling mid-transaction: the transaction completes and ready still pulses.
//  Requester inputs are sampled only in IDLE; later changes are ignored.
//  Lock held but locked requester not valid in IDLE: lock dropped, normal RR applies.
//  mem_addr/mem_wdata hold their last values outside ACCESS. mem_wen is 0 outside ACCESS.
// TESTING
//  1) Reset, then req1 read addr 5 (SRAM[5]=0xDEADBEEF), MEM_LAT=1 -> rq_ready[1] at
//     T+3, rq_rdata=0xDEADBEEF, mem_wen=0 throughout.
//  2) req0,1,2 valid together from reset, held -> grants in order 0,1,2,0.
//     Each ready is 4 cycles apart.
//  3) req2 write addr 10, wstrb 4'b0011, wdata 0x12345678 -> mem_wen=0011 for exactly one
//     cycle, mem_addr=10. A following read of addr 10 returns the low half updated.
//  4) req0 lock=1, 20 back-to-back reads, with req1 also valid -> req0 granted 16 in a row,
//     then req1 granted, then req0 resumes.
//  5) req1 write addr 1024 (MEM_WORDS=1024) -> mem_wen stays 0, rq_ready[1] still pulses,
//     and a read of addr 1024 gives rq_rdata=0.
//  6) resetn low during WAIT -> no rq_ready, busy=0 and mem_wen=0 next cycle,
//     and the next grant goes to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and SRAM-side signals of the shared memory port arbiter.
// The arbiter takes the slave view; the requesters/SRAM environment takes the master view.
interface mem_port_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 22
);
  logic [NREQ-1:0]        rq_valid;
  logic [NREQ-1:0]        rq_lock;
  logic [NREQ*ADDR_W-1:0] rq_addr;
  logic [NREQ*4-1:0]      rq_wstrb;
  logic [NREQ*32-1:0]     rq_wdata;
  logic [NREQ-1:0]        rq_ready;
  logic [31:0]            rq_rdata;
  logic [2:0]             grant_id;
  logic                   busy;
  logic [3:0]             mem_wen;
  logic [ADDR_W-1:0]      mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  modport slave (
    input  rq_valid, rq_lock, rq_addr, rq_wstrb, rq_wdata, mem_rdata,
    output rq_ready, rq_rdata, grant_id, busy, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output rq_valid, rq_lock, rq_addr, rq_wstrb, rq_wdata, mem_rdata,
    input  rq_ready, rq_rdata, grant_id, busy, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NREQ requesters, one transaction
// in flight, with an optional per-requester lock capped at LOCK_MAX consecutive grants.
module mem_port_arbiter #(
  parameter int NREQ      = 3,
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 22,
  parameter int MEM_LAT   = 1,
  parameter int LOCK_MAX  = 16
) (
  input logic             clk,
  input logic             resetn,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam int          CNT_W  = $clog2(LOCK_MAX + 1);
  localparam int          WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

  state_t            r_state;
  logic [2:0]        r_rr_ptr;
  logic [2:0]        r_grant_id;
  logic [2:0]        r_lock_id;
  logic              r_lock_valid;
  logic              r_lock_req;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_oor;
  logic              r_busy;
  logic [NREQ-1:0]   r_ready;
  logic [31:0]       r_rdata;
  logic [3:0]        r_mem_wen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [7:0]        w_valid_ext;
  logic [7:0]        w_lock_ext;
  logic [7:0]        w_onehot;
  logic              w_lock_hit;
  logic              w_any;
  logic [2:0]        w_win;
  logic [3:0]        w_sum;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic              w_oor;

  // Widen to 8 bits so a 3-bit requester index always selects in range.
  assign w_valid_ext = 8'(bus.rq_valid);
  assign w_lock_ext  = 8'(bus.rq_lock);
  assign w_onehot    = 8'd1 << r_grant_id;
  assign w_lock_hit  = r_lock_valid && w_valid_ext[r_lock_id];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_any = 1'b0;
    w_win = r_lock_id;
    w_sum = '0;
    if (w_lock_hit) begin
      w_any = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        w_sum = {1'b0, r_rr_ptr} + 4'(k);
        if (w_sum >= 4'(NREQ)) w_sum = w_sum - 4'(NREQ);
        if (!w_any && w_valid_ext[w_sum[2:0]]) begin
          w_any = 1'b1;
          w_win = w_sum[2:0];
        end
      end
    end
  end

  assign w_addr  = bus.rq_addr[int'(w_win)*ADDR_W +: ADDR_W];
  assign w_wstrb = bus.rq_wstrb[int'(w_win)*4 +: 4];
  assign w_wdata = bus.rq_wdata[int'(w_win)*32 +: 32];
  assign w_oor   = 32'(w_addr) >= MEM_WORDS_U;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_lock_id    <= '0;
      r_lock_valid <= 1'b0;
      r_lock_req   <= 1'b0;
      r_lock_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_oor        <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= '0;
      r_rdata      <= '0;
      r_mem_wen    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_ready <= '0;
      case (r_state)
        S_IDLE: begin
          // A lock whose owner is not requesting this cycle is abandoned.
          if (r_lock_valid && !w_lock_hit) begin
            r_lock_valid <= 1'b0;
            r_lock_cnt   <= '0;
          end
          if (w_any) begin
            r_grant_id  <= w_win;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_wen   <= w_oor ? 4'b0000 : w_wstrb;
            r_oor       <= w_oor;
            r_lock_req  <= w_lock_ext[w_win];
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_wen  <= '0;
          r_wait_cnt <= WAIT_W'(MEM_LAT - 1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_rdata <= r_oor ? 32'h0 : bus.mem_rdata;
            r_ready <= w_onehot[NREQ-1:0];
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_rr_ptr <= (r_grant_id == 3'(NREQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
          if (r_lock_req && (int'(r_lock_cnt) < LOCK_MAX - 1)) begin
            r_lock_valid <= 1'b1;
            r_lock_id    <= r_grant_id;
            r_lock_cnt   <= r_lock_cnt + 1'b1;
          end else begin
            r_lock_valid <= 1'b0;
            r_lock_cnt   <= '0;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rq_ready  = r_ready;
  assign bus.rq_rdata  = r_rdata;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = r_busy;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule
